// File: rtl/display_pkg.sv
// Shared widths, beat field layout and FSM state type for the display pixel packer.
package display_pkg;

  localparam int PIX_W  = 24;
  localparam int BEAT_W = 64;

  localparam int P0_LSB = 0;
  localparam int P1_LSB = 32;
  localparam int R_OFF  = 0;
  localparam int G_OFF  = 8;
  localparam int B_OFF  = 16;

  localparam logic [7:0] KEEP_ALL = 8'hFF;

  typedef enum logic [1:0] {
    SEEK_SOF  = 2'd0,
    PACK_EVEN = 2'd1,
    PACK_ODD  = 2'd2
  } pack_state_t;

  // First pixel lands in the low half, second in the high half; bytes 3 and 7 stay zero.
  function automatic logic [BEAT_W-1:0] pack_beat(input logic [PIX_W-1:0] first,
                                                  input logic [PIX_W-1:0] second);
    logic [BEAT_W-1:0] beat;
    beat = '0;
    beat[P0_LSB+R_OFF +: 8] = first[R_OFF +: 8];
    beat[P0_LSB+G_OFF +: 8] = first[G_OFF +: 8];
    beat[P0_LSB+B_OFF +: 8] = first[B_OFF +: 8];
    beat[P1_LSB+R_OFF +: 8] = second[R_OFF +: 8];
    beat[P1_LSB+G_OFF +: 8] = second[G_OFF +: 8];
    beat[P1_LSB+B_OFF +: 8] = second[B_OFF +: 8];
    return beat;
  endfunction

endpackage

// File: rtl/display_beat_fifo2.sv
// Two-entry register FIFO for packed display beats; slot0 is always the head.
module display_beat_fifo2
  import display_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [BEAT_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [BEAT_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [1:0]        count
);

  logic [BEAT_W-1:0] slot0;
  logic [BEAT_W-1:0] slot1;
  logic              rd_fire;
  logic              wr_fire;

  assign rd_valid = (count != 2'd0);
  assign rd_data  = rd_valid ? slot0 : '0;
  assign rd_fire  = rd_valid & rd_ready;
  // A write at full occupancy is only taken when the same cycle frees the head.
  assign wr_fire  = wr_valid & ((count != 2'd2) | rd_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10: begin
          if (count == 2'd0) slot0 <= wr_data;
          else               slot1 <= wr_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= wr_data;
          end else begin
            slot0 <= slot1;
            slot1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/display_pixel_packer.sv
// Packs an RGB888 pixel stream into two-pixel display beats, checking line/frame geometry.
// state     | meaning
// SEEK_SOF  | discarding pixels until one carries user (start of frame)
// PACK_EVEN | next pixel opens a pair (or must be SOF right after a frame ends)
// PACK_ODD  | hold register valid; next pixel completes the pair
module display_pixel_packer
  import display_pkg::*;
#(
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480
) (
  input  logic              lvds_slowclk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  s_pix_data,
  input  logic              s_pix_valid,
  input  logic              s_pix_user,
  input  logic              s_pix_last,
  output logic              s_pix_ready,
  output logic [BEAT_W-1:0] display_dma_rdata,
  output logic              display_dma_rvalid,
  output logic [7:0]        display_dma_rkeep,
  input  logic              display_dma_rready,
  output logic              frame_sync_err,
  output logic              line_len_err,
  output logic [31:0]       debug_frame_count,
  output logic [31:0]       debug_drop_count
);

  localparam int X_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int Y_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_LINES - 1);

  pack_state_t       state;
  pack_state_t       state_nxt;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [PIX_W-1:0]  hold;
  logic              at_sof;
  logic [1:0]        fifo_count;

  logic              acc;
  logic              x_end;
  logic              eol;
  logic              sof_take;
  logic              miss_sof;
  logic              pix_even;
  logic              pix_odd;
  logic              line_end;
  logic              drop;
  logic              sync_bad;
  logic              beat_wr;
  logic [BEAT_W-1:0] beat_data;

  assign s_pix_ready = ~rst & ((state == SEEK_SOF) | (fifo_count != 2'd2));
  assign acc      = s_pix_valid & s_pix_ready;
  assign x_end    = (x == X_LAST);
  assign eol      = s_pix_last | x_end;
  assign sof_take = acc & s_pix_user;
  assign miss_sof = acc & ~s_pix_user & (state == PACK_EVEN) & at_sof;
  assign pix_even = acc & ~s_pix_user & (state == PACK_EVEN) & ~at_sof;
  assign pix_odd  = acc & ~s_pix_user & (state == PACK_ODD);
  assign line_end = (pix_even | pix_odd) & eol;
  assign drop     = (acc & ~s_pix_user & (state == SEEK_SOF)) | miss_sof;
  // SOF is only legal from SEEK_SOF or directly after a completed frame.
  assign sync_bad = miss_sof |
                    (sof_take & ((state == PACK_ODD) | ((state == PACK_EVEN) & ~at_sof)));

  always_ff @(posedge lvds_slowclk) begin
    if (rst) state <= SEEK_SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEEK_SOF: begin
        if (sof_take) state_nxt = PACK_ODD;
      end
      PACK_EVEN: begin
        if (sof_take || (pix_even && !eol)) state_nxt = PACK_ODD;
        else if (miss_sof)                  state_nxt = SEEK_SOF;
      end
      PACK_ODD: begin
        if (pix_odd) state_nxt = PACK_EVEN;
      end
      default: state_nxt = SEEK_SOF;
    endcase
  end

  always_comb begin
    beat_wr   = 1'b0;
    beat_data = '0;
    if (sof_take && (state == PACK_ODD)) begin
      beat_wr   = 1'b1;
      beat_data = pack_beat(hold, '0);
    end else if (pix_odd) begin
      beat_wr   = 1'b1;
      beat_data = pack_beat(hold, s_pix_data);
    end else if (pix_even && eol) begin
      beat_wr   = 1'b1;
      beat_data = pack_beat(s_pix_data, '0);
    end
  end

  always_ff @(posedge lvds_slowclk) begin
    if (rst) begin
      x                 <= '0;
      y                 <= '0;
      hold              <= '0;
      at_sof            <= 1'b0;
      frame_sync_err    <= 1'b0;
      line_len_err      <= 1'b0;
      debug_frame_count <= '0;
      debug_drop_count  <= '0;
    end else begin
      if (sof_take) begin
        hold   <= s_pix_data;
        x      <= X_W'(1);
        y      <= '0;
        at_sof <= 1'b0;
      end else if (line_end) begin
        x <= '0;
        if (y == Y_LAST) begin
          y                 <= '0;
          at_sof            <= 1'b1;
          debug_frame_count <= debug_frame_count + 32'd1;
        end else begin
          y <= y + Y_W'(1);
        end
      end else if (pix_even | pix_odd) begin
        x <= x + X_W'(1);
        if (pix_even) hold <= s_pix_data;
      end else if (miss_sof) begin
        at_sof <= 1'b0;
      end
      if (drop)     debug_drop_count <= debug_drop_count + 32'd1;
      if (sync_bad) frame_sync_err   <= 1'b1;
      if (line_end && (s_pix_last != x_end)) line_len_err <= 1'b1;
    end
  end

  display_beat_fifo2 u_fifo (
    .clk      (lvds_slowclk),
    .rst      (rst),
    .wr_valid (beat_wr),
    .wr_data  (beat_data),
    .rd_valid (display_dma_rvalid),
    .rd_data  (display_dma_rdata),
    .rd_ready (display_dma_rready),
    .count    (fifo_count)
  );

  assign display_dma_rkeep = display_dma_rvalid ? KEEP_ALL : 8'h00;

endmodule

// File: tb/tb_display_pixel_packer.sv
// Bench for display_pixel_packer: directed vectors, corner sequences and a queue-based scoreboard.
module tb_display_pixel_packer;

  localparam int LP = 4;
  localparam int FL = 2;

  logic        lvds_slowclk = 1'b0;
  logic        rst;
  logic [23:0] s_pix_data;
  logic        s_pix_valid;
  logic        s_pix_user;
  logic        s_pix_last;
  logic        s_pix_ready;
  logic [63:0] display_dma_rdata;
  logic        display_dma_rvalid;
  logic [7:0]  display_dma_rkeep;
  logic        display_dma_rready;
  logic        frame_sync_err;
  logic        line_len_err;
  logic [31:0] debug_frame_count;
  logic [31:0] debug_drop_count;

  always #5 lvds_slowclk = ~lvds_slowclk;

  display_pixel_packer #(.LINE_PIXELS(LP), .FRAME_LINES(FL)) dut (
    .lvds_slowclk       (lvds_slowclk),
    .rst                (rst),
    .s_pix_data         (s_pix_data),
    .s_pix_valid        (s_pix_valid),
    .s_pix_user         (s_pix_user),
    .s_pix_last         (s_pix_last),
    .s_pix_ready        (s_pix_ready),
    .display_dma_rdata  (display_dma_rdata),
    .display_dma_rvalid (display_dma_rvalid),
    .display_dma_rkeep  (display_dma_rkeep),
    .display_dma_rready (display_dma_rready),
    .frame_sync_err     (frame_sync_err),
    .line_len_err       (line_len_err),
    .debug_frame_count  (debug_frame_count),
    .debug_drop_count   (debug_drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stream-level view of frames, lines and a two-beat output buffer.
  logic [63:0] m_beats[$];
  logic [23:0] m_pend[$];
  bit          m_seek;
  bit          m_expect_sof;
  bit          m_sync_err;
  bit          m_len_err;
  int          m_px;
  int          m_line;
  logic [31:0] m_frames;
  logic [31:0] m_drops;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pair(input logic [23:0] a, input logic [23:0] b);
    return {8'h00, b, 8'h00, a};
  endfunction

  function automatic bit model_ready();
    return (rst !== 1'b1) && (m_seek || (m_beats.size() < 2));
  endfunction

  task automatic model_reset();
    m_beats.delete();
    m_pend.delete();
    m_seek = 1; m_expect_sof = 0; m_sync_err = 0; m_len_err = 0;
    m_px = 0; m_line = 0; m_frames = 0; m_drops = 0;
  endtask

  task automatic start_frame(input logic [23:0] p);
    m_seek = 0; m_expect_sof = 0;
    m_pend.delete();
    m_pend.push_back(p);
    m_px = 1; m_line = 0;
  endtask

  task automatic model_pixel(input logic [23:0] d, input bit u, input bit l);
    if (m_seek) begin
      if (u) start_frame(d);
      else   m_drops++;
    end else if (m_expect_sof && !u) begin
      m_sync_err = 1; m_drops++; m_seek = 1; m_expect_sof = 0;
    end else if (u) begin
      if (!m_expect_sof) m_sync_err = 1;
      if (m_pend.size() == 1) m_beats.push_back(pair(m_pend[0], 24'h0));
      start_frame(d);
    end else begin
      m_pend.push_back(d);
      m_px++;
      if (m_pend.size() == 2) begin
        m_beats.push_back(pair(m_pend[0], m_pend[1]));
        m_pend.delete();
      end
      if (l || (m_px == LP)) begin
        if (l != (m_px == LP)) m_len_err = 1;
        if (m_pend.size() == 1) begin
          m_beats.push_back(pair(m_pend[0], 24'h0));
          m_pend.delete();
        end
        m_px = 0;
        m_line++;
        if (m_line == FL) begin
          m_line = 0; m_frames++; m_expect_sof = 1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("s_pix_ready", 64'(s_pix_ready), 64'(model_ready()));
    chk("rvalid", 64'(display_dma_rvalid), 64'(m_beats.size() > 0));
    chk("rkeep", 64'(display_dma_rkeep), (m_beats.size() > 0) ? 64'hFF : 64'h0);
    if (m_beats.size() > 0) chk("rdata", display_dma_rdata, m_beats[0]);
    chk("frame_sync_err", 64'(frame_sync_err), 64'(m_sync_err));
    chk("line_len_err", 64'(line_len_err), 64'(m_len_err));
    chk("frame_count", 64'(debug_frame_count), 64'(m_frames));
    chk("drop_count", 64'(debug_drop_count), 64'(m_drops));
  endtask

  task automatic advance();
    bit acc, pop;
    acc = s_pix_valid && model_ready();
    pop = display_dma_rready && (m_beats.size() > 0);
    @(posedge lvds_slowclk);
    if (rst) begin
      model_reset();
    end else begin
      if (pop) void'(m_beats.pop_front());
      if (acc) model_pixel(s_pix_data, s_pix_user, s_pix_last);
    end
    #1;
  endtask

  task automatic tick(input bit v, input logic [23:0] d, input bit u, input bit l, input bit rr);
    s_pix_valid = v; s_pix_data = d; s_pix_user = u; s_pix_last = l;
    display_dma_rready = rr;
    @(negedge lvds_slowclk);
    check_model();
    advance();
  endtask

  task automatic send(input logic [23:0] d, input bit u, input bit l);
    bit done;
    int guard;
    done = 0; guard = 0;
    while (!done && guard < 64) begin
      done = model_ready();
      tick(1'b1, d, u, l, 1'b1);
      guard++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: pixel %h not accepted in 64 cycles, required acceptance", d);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    bit          valid;
    logic [23:0] data;
    bit          user;
    bit          last;
    bit          rready;
    bit          exp_rvalid;
    logic [63:0] exp_rdata;
    logic [31:0] exp_frames;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 24'h030201, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 32'd0};
    vecs[1] = '{1'b1, 24'h060504, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0006_0504_0003_0201, 32'd0};
    vecs[2] = '{1'b1, 24'h090807, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 32'd0};
    vecs[3] = '{1'b1, 24'h0C0B0A, 1'b0, 1'b1, 1'b1, 1'b1, 64'h000C_0B0A_0009_0807, 32'd0};
    vecs[4] = '{1'b1, 24'h0F0E0D, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 32'd0};
    vecs[5] = '{1'b1, 24'h121110, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0012_1110_000F_0E0D, 32'd0};
    vecs[6] = '{1'b1, 24'h151413, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 32'd0};
    vecs[7] = '{1'b1, 24'h181716, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0018_1716_0015_1413, 32'd1};
    vecs[8] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 32'd1};
    vecs[9] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 32'd1};

    rst = 1'b1;
    s_pix_valid = 1'b0; s_pix_data = '0; s_pix_user = 1'b0; s_pix_last = 1'b0;
    display_dma_rready = 1'b0;
    model_reset();
    @(posedge lvds_slowclk);
    #1;

    // Reset held three cycles: everything quiet.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
      chk("rst_ready", 64'(s_pix_ready), 64'h0);
      chk("rst_rvalid", 64'(display_dma_rvalid), 64'h0);
      chk("rst_rkeep", 64'(display_dma_rkeep), 64'h0);
      chk("rst_rdata", display_dma_rdata, 64'h0);
      chk("rst_errs", {62'h0, frame_sync_err, line_len_err}, 64'h0);
      chk("rst_counts", {debug_frame_count, debug_drop_count}, 64'h0);
    end
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(s_pix_ready), 64'h1);
    chk("rvalid_after_rst", 64'(display_dma_rvalid), 64'h0);

    // Nominal frame from the vector table.
    for (int i = 0; i < 10; i++) begin
      tick(vecs[i].valid, vecs[i].data, vecs[i].user, vecs[i].last, vecs[i].rready);
      chk($sformatf("vec%0d_rvalid", i), 64'(display_dma_rvalid), 64'(vecs[i].exp_rvalid));
      if (vecs[i].exp_rvalid) chk($sformatf("vec%0d_rdata", i), display_dma_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_frames", i), 64'(debug_frame_count), 64'(vecs[i].exp_frames));
    end
    chk("nominal_errs", {62'h0, frame_sync_err, line_len_err}, 64'h0);

    // Garbage before SOF, then a clean frame.
    do_reset(2);
    for (int i = 0; i < 3; i++) send(24'hDEAD00 + 24'(i), 1'b0, 1'b0);
    for (int k = 0; k < LP * FL; k++) begin
      send(24'h100000 + 24'(k), k == 0, (k % LP) == LP - 1);
      if (k == 1) chk("sof_beat", display_dma_rdata, 64'h0010_0001_0010_0000);
    end
    chk("drop_count_3", 64'(debug_drop_count), 64'd3);
    chk("garbage_frames", 64'(debug_frame_count), 64'd1);

    // Short line: last on x=2, then a full line starting at x=0.
    send(24'h200000, 1'b1, 1'b0);
    send(24'h200001, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b1);
    chk("short_beat", display_dma_rdata, 64'h0000_0000_00AA_BBCC);
    chk("short_len_err", 64'(line_len_err), 64'h1);
    send(24'h200010, 1'b0, 1'b0);
    send(24'h200011, 1'b0, 1'b0);
    chk("after_short_beat", display_dma_rdata, 64'h0020_0011_0020_0010);
    send(24'h200012, 1'b0, 1'b0);
    send(24'h200013, 1'b0, 1'b1);
    chk("short_frames", 64'(debug_frame_count), 64'd2);
    chk("short_sync_err", 64'(frame_sync_err), 64'h0);

    // Backpressure: two beats buffered, then ten stalled cycles.
    do_reset(2);
    tick(1'b1, 24'h300000, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 24'h300001, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 24'h300002, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 24'h300003, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready_low", 64'(s_pix_ready), 64'h0);
      chk("bp_rvalid", 64'(display_dma_rvalid), 64'h1);
      chk("bp_rdata_stable", display_dma_rdata, 64'h0030_0001_0030_0000);
      tick(1'b1, 24'h300004, 1'b0, 1'b0, 1'b0);
    end
    tick(1'b1, 24'h300004, 1'b0, 1'b0, 1'b1);
    chk("bp_second_beat", display_dma_rdata, 64'h0030_0003_0030_0002);
    for (int k = 4; k < 8; k++) send(24'h300000 + 24'(k), 1'b0, k == 7);
    for (int i = 0; i < 4; i++) tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    chk("bp_errs", {62'h0, frame_sync_err, line_len_err}, 64'h0);
    chk("bp_frames", 64'(debug_frame_count), 64'd1);

    // SOF arriving mid-pair.
    do_reset(2);
    send(24'h112233, 1'b1, 1'b0);
    send(24'h445566, 1'b1, 1'b0);
    chk("pad_beat", display_dma_rdata, 64'h0000_0000_0011_2233);
    chk("mid_sof_err", 64'(frame_sync_err), 64'h1);
    send(24'h778899, 1'b0, 1'b0);
    chk("resync_beat", display_dma_rdata, 64'h0077_8899_0044_5566);
    send(24'hAA0002, 1'b0, 1'b0);
    send(24'hAA0003, 1'b0, 1'b1);
    for (int k = 0; k < LP; k++) send(24'hAB0000 + 24'(k), 1'b0, k == LP - 1);
    chk("resync_frames", 64'(debug_frame_count), 64'd1);
    chk("resync_len_err", 64'(line_len_err), 64'h0);

    // Missing SOF after a complete frame.
    do_reset(2);
    for (int k = 0; k < LP * FL; k++) send(24'h600000 + 24'(k), k == 0, (k % LP) == LP - 1);
    chk("pre_miss_sync", 64'(frame_sync_err), 64'h0);
    send(24'h500000, 1'b0, 1'b0);
    chk("miss_sync_err", 64'(frame_sync_err), 64'h1);
    chk("miss_drop", 64'(debug_drop_count), 64'd1);
    send(24'h510000, 1'b1, 1'b0);
    send(24'h510001, 1'b0, 1'b0);
    chk("miss_resync_beat", display_dma_rdata, 64'h0051_0001_0051_0000);

    // Reset while a beat is buffered.
    tick(1'b1, 24'h700000, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 24'h700001, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(s_pix_ready), 64'h0);
    tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    chk("midrst_rvalid", 64'(display_dma_rvalid), 64'h0);
    chk("midrst_rkeep", 64'(display_dma_rkeep), 64'h0);
    chk("midrst_counts", {debug_frame_count, debug_drop_count}, 64'h0);
    rst = 1'b0;
    #1;

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      bit v, u, l, rr;
      v  = ($urandom_range(0, 9) < 8);
      u  = ($urandom_range(0, 19) == 0);
      l  = !u && ($urandom_range(0, 7) == 0);
      rr = ($urandom_range(0, 9) < 7);
      tick(v, 24'($urandom), u, l, rr);
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
